// File: rtl/mastermind_round_ctrl.sv
// Mastermind game sequencer: selects the code maker, collects 4-digit guesses,
// scores exact/misplaced pegs and keeps per-player scores over a fixed number of rounds.
module mastermind_round_ctrl #(
  parameter int unsigned MAX_GUESSES = 6,
  parameter int unsigned ROUNDS      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        enterA,
  input  logic        enterB,
  input  logic [2:0]  SW,
  input  logic        started,
  input  logic [11:0] code_in,
  output logic        code_maker_go,
  output logic        maker_is_a,
  output logic [11:0] guess,
  output logic [2:0]  exact,
  output logic [2:0]  misplaced,
  output logic        result_valid,
  output logic [2:0]  guess_cnt,
  output logic [2:0]  round_cnt,
  output logic [2:0]  score_a,
  output logic [2:0]  score_b,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DW     = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MAKE    = 3'd1,
    GUESS   = 3'd2,
    EVAL    = 3'd3,
    RND_END = 3'd4,
    OVER    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [11:0] secret;
  logic [2:0]  dig_cnt;

  logic        accept_c;
  logic [2:0]  exact_c;
  logic [2:0]  total_c;
  logic [2:0]  misplaced_c;
  logic [2:0]  guess_cnt_inc_c;
  logic [2:0]  round_cnt_inc_c;
  logic [1:0]  win_c;

  // Number of digit positions in w holding value v.
  function automatic logic [2:0] digit_count(input logic [11:0] w, input logic [2:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      n = n + 3'(w[DW*i +: DW] == v);
    end
    return n;
  endfunction

  // Peg scoring of the current guess against the secret.
  always_comb begin
    exact_c = '0;
    total_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      exact_c = exact_c + 3'(guess[DW*i +: DW] == secret[DW*i +: DW]);
    end
    for (int v = 0; v < 8; v++) begin
      if (digit_count(guess, 3'(v)) < digit_count(secret, 3'(v))) begin
        total_c = total_c + digit_count(guess, 3'(v));
      end else begin
        total_c = total_c + digit_count(secret, 3'(v));
      end
    end
    misplaced_c = total_c - exact_c;
  end

  always_comb begin
    accept_c        = (state == GUESS) && (maker_is_a ? enterB : enterA);
    guess_cnt_inc_c = guess_cnt + 3'd1;
    round_cnt_inc_c = round_cnt + 3'd1;
    if (score_a > score_b) begin
      win_c = 2'b01;
    end else if (score_b > score_a) begin
      win_c = 2'b10;
    end else begin
      win_c = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAKE;
      MAKE:    if (started) state_nx = GUESS;
      GUESS:   if (accept_c && (dig_cnt == 3'(DIGITS - 1))) state_nx = EVAL;
      EVAL: begin
        if ((exact_c == 3'(DIGITS)) || (guess_cnt_inc_c == 3'(MAX_GUESSES))) begin
          state_nx = RND_END;
        end else begin
          state_nx = GUESS;
        end
      end
      RND_END: state_nx = (round_cnt_inc_c == 3'(ROUNDS)) ? OVER : MAKE;
      OVER:    if (start) state_nx = MAKE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs; Moore flags follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secret        <= '0;
      dig_cnt       <= '0;
      code_maker_go <= 1'b0;
      maker_is_a    <= 1'b0;
      guess         <= '0;
      exact         <= '0;
      misplaced     <= '0;
      result_valid  <= 1'b0;
      guess_cnt     <= '0;
      round_cnt     <= '0;
      score_a       <= '0;
      score_b       <= '0;
      game_over     <= 1'b0;
      winner        <= '0;
    end else begin
      result_valid  <= 1'b0;
      code_maker_go <= (state_nx == MAKE);
      game_over     <= (state_nx == OVER);
      winner        <= (state_nx == OVER) ? win_c : 2'b00;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score_a    <= '0;
            score_b    <= '0;
            round_cnt  <= '0;
            guess_cnt  <= '0;
            guess      <= '0;
            dig_cnt    <= '0;
            maker_is_a <= 1'b1;
          end
        end
        MAKE: begin
          if (started) begin
            secret  <= code_in;
            guess   <= '0;
            dig_cnt <= '0;
          end
        end
        GUESS: begin
          if (accept_c) begin
            guess   <= {guess[8:0], SW};
            dig_cnt <= dig_cnt + 3'd1;
          end
        end
        EVAL: begin
          exact        <= exact_c;
          misplaced    <= misplaced_c;
          result_valid <= 1'b1;
          guess_cnt    <= guess_cnt_inc_c;
          dig_cnt      <= '0;
          // Breaker scores on a full hit; the maker scores when guesses run out.
          if (exact_c == 3'(DIGITS)) begin
            if (maker_is_a) score_b <= score_b + 3'd1;
            else            score_a <= score_a + 3'd1;
          end else if (guess_cnt_inc_c == 3'(MAX_GUESSES)) begin
            if (maker_is_a) score_a <= score_a + 3'd1;
            else            score_b <= score_b + 3'd1;
          end
        end
        RND_END: begin
          round_cnt  <= round_cnt_inc_c;
          maker_is_a <= ~maker_is_a;
          guess_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Scoreboard bench for mastermind_round_ctrl: expected peg results are queued by
// the stimulus and checked by a monitor on every result_valid pulse.
module tb_mastermind_round_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        enterA = 1'b0;
  logic        enterB = 1'b0;
  logic [2:0]  SW = '0;
  logic        started = 1'b0;
  logic [11:0] code_in = '0;
  logic        code_maker_go;
  logic        maker_is_a;
  logic [11:0] guess;
  logic [2:0]  exact;
  logic [2:0]  misplaced;
  logic        result_valid;
  logic [2:0]  guess_cnt;
  logic [2:0]  round_cnt;
  logic [2:0]  score_a;
  logic [2:0]  score_b;
  logic        game_over;
  logic [1:0]  winner;

  typedef struct packed {
    logic [2:0] ex;
    logic [2:0] mis;
    logic [2:0] gc;
    logic [2:0] sa;
    logic [2:0] sb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  mastermind_round_ctrl #(.MAX_GUESSES(6), .ROUNDS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .enterA(enterA), .enterB(enterB),
    .SW(SW), .started(started), .code_in(code_in), .code_maker_go(code_maker_go),
    .maker_is_a(maker_is_a), .guess(guess), .exact(exact), .misplaced(misplaced),
    .result_valid(result_valid), .guess_cnt(guess_cnt), .round_cnt(round_cnt),
    .score_a(score_a), .score_b(score_b), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected actual ex=%0d mis=%0d required none", exact, misplaced);
      end else begin
        chk("result", 36'({exact, misplaced, guess_cnt, score_a, score_b}), 36'(q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic a, input logic b, input logic [2:0] d);
    enterA = a; enterB = b; SW = d;
    cyc(1);
    enterA = 1'b0; enterB = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic load_code(input logic [11:0] c);
    cyc(2);
    code_in = c; started = 1'b1;
    cyc(1);
    started = 1'b0;
  endtask

  // brk_a = 1 when player A is the breaker; returns in the EVAL cycle.
  task automatic do_guess(input logic brk_a, input logic [2:0] d0, input logic [2:0] d1,
                          input logic [2:0] d2, input logic [2:0] d3, input exp_t e);
    q.push_back(e);
    pulse(brk_a, !brk_a, d0);
    pulse(brk_a, !brk_a, d1);
    pulse(brk_a, !brk_a, d2);
    pulse(brk_a, !brk_a, d3);
  endtask

  function automatic exp_t mk(input int ex, input int mis, input int gc, input int sa, input int sb);
    exp_t e;
    e.ex = 3'(ex); e.mis = 3'(mis); e.gc = 3'(gc); e.sa = 3'(sa); e.sb = 3'(sb);
    return e;
  endfunction

  function automatic logic [35:0] all_outs();
    return {code_maker_go, maker_is_a, guess, exact, misplaced, result_valid,
            guess_cnt, round_cnt, score_a, score_b, game_over, winner};
  endfunction

  initial begin
    cyc(2);
    chk("reset_outputs", all_outs(), 36'd0);
    reset = 1'b0;
    cyc(1);

    // Game 1, round 0: A makes code 1,2,3,4, B breaks.
    do_start();
    chk("go_after_start", 36'({code_maker_go, maker_is_a}), 36'(2'b11));
    load_code(12'h29C);
    chk("go_drops_in_guess", 36'(code_maker_go), 36'd0);
    do_guess(1'b0, 3'd4, 3'd3, 3'd2, 3'd1, mk(0, 4, 1, 0, 0));
    pulse(1'b0, 1'b1, 3'd7);
    chk("eval_enter_dropped", 36'(guess), 36'h8D1);
    do_guess(1'b0, 3'd1, 3'd2, 3'd4, 3'd3, mk(2, 2, 2, 0, 0));
    cyc(1);
    chk("guess_held", 36'(guess), 36'h2A3);
    pulse(1'b1, 1'b0, 3'd7);
    chk("maker_enter_ignored", 36'(guess), 36'h2A3);
    pulse(1'b1, 1'b1, 3'd1);
    chk("both_enters_one_digit", 36'(guess), 36'h519);
    q.push_back(mk(4, 0, 3, 0, 1));
    pulse(1'b0, 1'b1, 3'd2);
    pulse(1'b0, 1'b1, 3'd3);
    pulse(1'b0, 1'b1, 3'd4);
    cyc(2);
    chk("round1_make", 36'({code_maker_go, maker_is_a, round_cnt, guess_cnt, score_b}),
        36'({1'b1, 1'b0, 3'd1, 3'd0, 3'd1}));

    // Game 1, round 1: B makes code 5,5,1,1, A breaks and wins.
    load_code(12'hB49);
    do_guess(1'b1, 3'd5, 3'd1, 3'd5, 3'd7, mk(1, 2, 1, 0, 1));
    cyc(1);
    do_guess(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, mk(0, 0, 2, 0, 1));
    cyc(1);
    do_guess(1'b1, 3'd5, 3'd5, 3'd1, 3'd1, mk(4, 0, 3, 1, 1));
    cyc(2);
    chk("game_over_tie", 36'({game_over, winner, round_cnt, code_maker_go, guess_cnt}),
        36'({1'b1, 2'b11, 3'd2, 1'b0, 3'd0}));

    // Game 2 from OVER: six wrong guesses give the maker (A) the point.
    do_start();
    chk("restart_from_over", 36'({code_maker_go, maker_is_a, round_cnt, score_a, score_b, game_over, winner}),
        36'({1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 2'b00}));
    load_code(12'h29C);
    do_guess(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, mk(0, 0, 1, 0, 0)); cyc(1);
    do_guess(1'b0, 3'd1, 3'd1, 3'd1, 3'd1, mk(1, 0, 2, 0, 0)); cyc(1);
    do_guess(1'b0, 3'd4, 3'd4, 3'd4, 3'd4, mk(1, 0, 3, 0, 0)); cyc(1);
    do_guess(1'b0, 3'd4, 3'd3, 3'd2, 3'd1, mk(0, 4, 4, 0, 0)); cyc(1);
    do_guess(1'b0, 3'd2, 3'd1, 3'd4, 3'd3, mk(0, 4, 5, 0, 0)); cyc(1);
    do_guess(1'b0, 3'd1, 3'd2, 3'd4, 3'd3, mk(2, 2, 6, 1, 0));
    cyc(2);
    chk("maker_point", 36'({score_a, score_b, round_cnt, maker_is_a, code_maker_go, guess_cnt}),
        36'({3'd1, 3'd0, 3'd1, 1'b0, 1'b1, 3'd0}));

    // Reset mid-guess with two digits entered, then a fresh game.
    load_code(12'h29C);
    pulse(1'b1, 1'b0, 3'd1);
    pulse(1'b1, 1'b0, 3'd2);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 36'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    do_start();
    chk("start_after_reset", 36'({code_maker_go, maker_is_a, round_cnt, score_a, score_b}),
        36'({1'b1, 1'b1, 3'd0, 3'd0, 3'd0}));
    load_code(12'h29C);
    do_guess(1'b0, 3'd1, 3'd2, 3'd3, 3'd4, mk(4, 0, 1, 0, 1));
    cyc(3);
    chk("scoreboard_drained", 36'(q.size()), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
